potential_adder_scheduler: RTL and testbench

//  Time-multiplexes one LIF potential adder (weight + decayed potential -> final potential, spike) across NUM_NEURONS neurons.
//  Per timestep: sequences the adder's clear/set phases, fetches each neuron's weight, presents the stored potential,
//  and captures the result. Also publishes the spike vector and a done pulse to the timestep controller.

---
 rtl/potential_sched_pkg.sv | 26 ++
 rtl/neuron_potential_regfile.sv | 39 +++
 rtl/potential_adder_scheduler.sv | 176 +++++++++++++++++
 tb/tb_potential_adder_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/potential_sched_pkg.sv
// Shared types and helpers for the LIF potential adder scheduler: FSM state
// encoding, the IEEE-754 zero constant and width helpers.
package potential_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      SET,
      FETCH,
      LATCH,
      EVAL,
      WRITE,
      DONE
   } sched_state_t;

   localparam logic [31:0] FP_ZERO = 32'h0000_0000;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int count_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/neuron_potential_regfile.sv
// Membrane potential storage: one synchronous write port, an asynchronous
// datapath read port and an asynchronous debug read port.
module neuron_potential_regfile
   import potential_sched_pkg::*;
#(
   parameter int          NUM_NEURONS = 30,
   parameter int          IDX_W       = idx_width(NUM_NEURONS),
   parameter logic [31:0] INIT_POT    = FP_ZERO
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             init,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [31:0]      wr_data,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [31:0]      rd_data,
   input  logic [IDX_W-1:0] dbg_idx,
   output logic [31:0]      dbg_data
);

   logic [31:0] pot [NUM_NEURONS];

   // A bulk reload (reset or init) takes priority over the scheduler's write-back.
   always_ff @(posedge clk) begin
      if (reset || init) begin
         for (int i = 0; i < NUM_NEURONS; i++) begin
            pot[i] <= INIT_POT;
         end
      end else if (wr_en) begin
         pot[wr_idx] <= wr_data;
      end
   end

   assign rd_data  = pot[rd_idx];
   assign dbg_data = pot[dbg_idx];

endmodule

// File: rtl/potential_adder_scheduler.sv
// Time-multiplexes one LIF potential adder across NUM_NEURONS neurons per timestep.
// Optional SPIKE_COUNT_EN adds a spike_count output (popcount of the last timestep).
module potential_adder_scheduler
   import potential_sched_pkg::*;
#(
   parameter int          NUM_NEURONS = 30,
   parameter int          IDX_W       = idx_width(NUM_NEURONS),
   parameter int          ADDER_WAIT  = 1,
   parameter logic [31:0] INIT_POT    = FP_ZERO
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   pot_init,
   output logic                   busy,
   output logic                   done,
   output logic [NUM_NEURONS-1:0] spike_vec,
   output logic                   wt_rd_en,
   output logic [IDX_W-1:0]       wt_addr,
   input  logic [31:0]            wt_rdata,
   output logic                   clear_adder,
   output logic                   set_adder,
   output logic [31:0]            adder_weight,
   output logic [31:0]            adder_potential,
   input  logic [31:0]            adder_final,
   input  logic                   adder_spike,
   input  logic [IDX_W-1:0]       dbg_idx,
   output logic [31:0]            dbg_pot
`ifdef SPIKE_COUNT_EN
   ,
   output logic [count_width(NUM_NEURONS)-1:0] spike_count
`endif
);

   localparam int               WAIT_W   = (ADDER_WAIT > 1) ? $clog2(ADDER_WAIT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
   localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(ADDER_WAIT - 1);

   sched_state_t           state;
   logic [IDX_W-1:0]       idx;
   logic [WAIT_W-1:0]      wait_cnt;
   logic [31:0]            wt_q;
   logic [31:0]            pot_q;
   logic [NUM_NEURONS-1:0] spk_shadow;
   logic [NUM_NEURONS-1:0] shadow_next;
   logic [31:0]            pot_rd;

   neuron_potential_regfile #(
      .NUM_NEURONS (NUM_NEURONS),
      .IDX_W       (IDX_W),
      .INIT_POT    (INIT_POT)
   ) u_regfile (
      .clk      (clk),
      .reset    (reset),
      .init     (pot_init && (state == IDLE)),
      .wr_en    (state == WRITE),
      .wr_idx   (idx),
      .wr_data  (adder_final),
      .rd_idx   (idx),
      .rd_data  (pot_rd),
      .dbg_idx  (dbg_idx),
      .dbg_data (dbg_pot)
   );

   // Shadow including the spike being written this cycle, so spike_vec can be
   // published on the same edge that raises done.
   always_comb begin
      shadow_next      = spk_shadow;
      shadow_next[idx] = adder_spike;
   end

   // The adder inputs come straight from registers loaded once per neuron, so
   // the combinational adder never sees a glitch and holds across other states.
   assign adder_weight    = wt_q;
   assign adder_potential = pot_q;
   assign wt_addr         = idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         idx         <= '0;
         wait_cnt    <= '0;
         wt_q        <= FP_ZERO;
         pot_q       <= FP_ZERO;
         spk_shadow  <= '0;
         spike_vec   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         wt_rd_en    <= 1'b0;
         clear_adder <= 1'b0;
         set_adder   <= 1'b0;
      end else begin
         done        <= 1'b0;
         wt_rd_en    <= 1'b0;
         clear_adder <= 1'b0;
         set_adder   <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state       <= CLR;
                  busy        <= 1'b1;
                  clear_adder <= 1'b1;
               end
            end
            CLR: begin
               state     <= SET;
               set_adder <= 1'b1;
            end
            SET: begin
               state    <= FETCH;
               wt_rd_en <= 1'b1;
            end
            FETCH: begin
               state <= LATCH;
            end
            LATCH: begin
               wt_q     <= wt_rdata;
               pot_q    <= pot_rd;
               wait_cnt <= '0;
               state    <= EVAL;
            end
            EVAL: begin
               if (wait_cnt == LAST_WAIT) begin
                  state <= WRITE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            WRITE: begin
               spk_shadow <= shadow_next;
               if (idx == LAST_IDX) begin
                  state     <= DONE;
                  spike_vec <= shadow_next;
                  done      <= 1'b1;
               end else begin
                  idx      <= idx + 1'b1;
                  state    <= FETCH;
                  wt_rd_en <= 1'b1;
               end
            end
            DONE: begin
               state      <= IDLE;
               busy       <= 1'b0;
               idx        <= '0;
               spk_shadow <= '0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef SPIKE_COUNT_EN
   localparam int CNT_W = count_width(NUM_NEURONS);

   logic [CNT_W-1:0] cnt_acc;

   // Running count bumped once per write-back; published together with spike_vec.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_acc     <= '0;
         spike_count <= '0;
      end else if (state == WRITE) begin
         if (idx == LAST_IDX) begin
            spike_count <= cnt_acc + CNT_W'(adder_spike);
            cnt_acc     <= '0;
         end else begin
            cnt_acc <= cnt_acc + CNT_W'(adder_spike);
         end
      end
   end
`endif

endmodule

// File: tb/tb_potential_adder_scheduler.sv
// Directed bench for potential_adder_scheduler with an integer-valued LIF adder
// model (threshold 40.0) and a one-cycle-latency weight memory.
module tb_potential_adder_scheduler;

   localparam int NUM_NEURONS = 30;
   localparam int IDX_W       = $clog2(NUM_NEURONS);
   localparam int ADDER_WAIT  = 1;
   localparam int LATENCY     = 3 + NUM_NEURONS * (3 + ADDER_WAIT);
   localparam int THRESH_INT  = 40;

   localparam logic [31:0] FP_0  = 32'h0000_0000;
   localparam logic [31:0] FP_1  = 32'h3F80_0000;
   localparam logic [31:0] FP_10 = 32'h4120_0000;
   localparam logic [31:0] FP_20 = 32'h41A0_0000;
   localparam logic [31:0] FP_30 = 32'h41F0_0000;
   localparam logic [31:0] FP_40 = 32'h4220_0000;
   localparam logic [31:0] FP_50 = 32'h4248_0000;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   start;
   logic                   pot_init;
   logic                   busy;
   logic                   done;
   logic [NUM_NEURONS-1:0] spike_vec;
   logic                   wt_rd_en;
   logic [IDX_W-1:0]       wt_addr;
   logic [31:0]            wt_rdata;
   logic                   clear_adder;
   logic                   set_adder;
   logic [31:0]            adder_weight;
   logic [31:0]            adder_potential;
   logic [31:0]            adder_final;
   logic                   adder_spike;
   logic [IDX_W-1:0]       dbg_idx;
   logic [31:0]            dbg_pot;
`ifdef SPIKE_COUNT_EN
   logic [$clog2(NUM_NEURONS+1)-1:0] spike_count;
`endif

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   logic [31:0] weights [NUM_NEURONS];

   potential_adder_scheduler #(
      .NUM_NEURONS (NUM_NEURONS),
      .ADDER_WAIT  (ADDER_WAIT),
      .INIT_POT    (FP_0)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .pot_init        (pot_init),
      .busy            (busy),
      .done            (done),
      .spike_vec       (spike_vec),
      .wt_rd_en        (wt_rd_en),
      .wt_addr         (wt_addr),
      .wt_rdata        (wt_rdata),
      .clear_adder     (clear_adder),
      .set_adder       (set_adder),
      .adder_weight    (adder_weight),
      .adder_potential (adder_potential),
      .adder_final     (adder_final),
      .adder_spike     (adder_spike),
      .dbg_idx         (dbg_idx),
      .dbg_pot         (dbg_pot)
`ifdef SPIKE_COUNT_EN
      ,
      .spike_count     (spike_count)
`endif
   );

   always #5 clk = ~clk;

   // Weight memory: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (wt_rd_en) wt_rdata <= weights[wt_addr];
   end

   // Small-integer float helpers; every potential in this bench is a whole number.
   function automatic int fpToInt(input logic [31:0] f);
      int e;
      logic [23:0] m;
      if (f[30:0] == 31'd0) return 0;
      e = int'(f[30:23]) - 127;
      m = {1'b1, f[22:0]};
      if (e < 0) return 0;
      return int'(m) >> (23 - e);
   endfunction

   function automatic logic [31:0] intToFp(input int v);
      int p;
      logic [31:0] m;
      if (v <= 0) return 32'h0;
      p = 0;
      for (int b = 0; b < 24; b++) if (v[b]) p = b;
      m = 32'(v) << (23 - p);
      return {1'b0, 8'(p + 127), m[22:0]};
   endfunction

   // LIF adder with subtractive reset: spike when the sum strictly exceeds 40.
   int adderSum;
   always_comb begin
      adderSum    = fpToInt(adder_weight) + fpToInt(adder_potential);
      adder_spike = (adderSum > THRESH_INT);
      adder_final = intToFp(adder_spike ? adderSum - THRESH_INT : adderSum);
   end

   // Protocol monitor: adder phase strobes and where adder inputs may change.
   int          clrCycles    = 0;
   int          setCycles    = 0;
   int          orderErrs    = 0;
   int          inputChanges = 0;
   logic [31:0] prevW        = '0;
   logic [31:0] prevP        = '0;
   logic [1:0]  rdHist       = '0;
   logic        clrPrev      = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         if (clear_adder) clrCycles++;
         if (set_adder) begin
            setCycles++;
            if (!clrPrev) orderErrs++;
         end
         if ((adder_weight !== prevW || adder_potential !== prevP) && !rdHist[1]) inputChanges++;
      end
      prevW   = adder_weight;
      prevP   = adder_potential;
      rdHist  = {rdHist[0], wt_rd_en};
      clrPrev = clear_adder;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One timestep. Latency counts rising edges from the one that samples start
   // to the one after which done is visible. Optionally re-pulses start at
   // cycle extraAt and watches adder inputs while neuron watchIdx is evaluated.
   task automatic applyStimulus(input bit withInit, input int extraAt,
                                input int watchIdx, input logic [31:0] watchW, input logic [31:0] watchP,
                                output int latency, output int dones, output int busyDrops,
                                output int busyAfter, output int watchHits);
      int cyc;
      int evalAt;
      start    = 1'b1;
      pot_init = withInit;
      @(posedge clk); #1;
      start     = 1'b0;
      pot_init  = 1'b0;
      cyc       = 1;
      latency   = -1;
      dones     = 0;
      busyDrops = 0;
      busyAfter = -1;
      watchHits = 0;
      evalAt    = -1;
      while (cyc <= LATENCY + 20) begin
         if (done) begin
            dones++;
            if (latency < 0) latency = cyc;
         end
         if (!busy && latency < 0) busyDrops++;
         if (latency >= 0 && cyc == latency + 1) busyAfter = int'(busy);
         if (watchIdx >= 0 && wt_rd_en && wt_addr == IDX_W'(watchIdx)) evalAt = cyc + 2;
         if (evalAt > 0 && cyc >= evalAt && cyc <= evalAt + ADDER_WAIT) begin
            watchHits++;
            checkOutput("eval_weight", adder_weight, watchW);
            checkOutput("eval_potential", adder_potential, watchP);
         end
         start = (cyc == extraAt);
         if (latency >= 0 && cyc >= latency + 4) break;
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
   endtask

   task automatic checkPot(input string tag, input int n, input logic [31:0] expected);
      dbg_idx = IDX_W'(n);
      #1;
      checkOutput(tag, dbg_pot, expected);
   endtask

   initial begin
      int lat, dn, drops, bAfter, hits;
      int c0, s0, o0, i0;
      int cyc;
      bit found;
      logic [NUM_NEURONS-1:0] expVec;
      logic [31:0] expPot [4];

      reset    = 1'b1;
      start    = 1'b0;
      pot_init = 1'b0;
      dbg_idx  = '0;
      for (int i = 0; i < NUM_NEURONS; i++) weights[i] = FP_0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_spike_vec", spike_vec, '0);
      checkOutput("rst_wt_rd_en", wt_rd_en, 1'b0);
      checkOutput("rst_clear_set", {clear_adder, set_adder}, 2'b00);
      checkOutput("rst_adder_in", {adder_weight, adder_potential}, 64'h0);
      checkOutput("rst_dbg_pot", dbg_pot, FP_0);
      reset = 1'b0;
      @(posedge clk); #1;

      $display("[TB] timestep 1: all weights 10.0");
      for (int i = 0; i < NUM_NEURONS; i++) weights[i] = FP_10;
      pot_init = 1'b1;
      @(posedge clk); #1;
      pot_init = 1'b0;
      c0 = clrCycles; s0 = setCycles; o0 = orderErrs; i0 = inputChanges;
      applyStimulus(1'b0, 0, 0, FP_10, FP_0, lat, dn, drops, bAfter, hits);
      checkOutput("t1_latency", lat, LATENCY);
      checkOutput("t1_done_count", dn, 1);
      checkOutput("t1_busy_drops", drops, 0);
      checkOutput("t1_busy_after", bAfter, 0);
      checkOutput("t1_watch_hits", hits, ADDER_WAIT + 1);
      checkOutput("t1_spike_vec", spike_vec, '0);
      checkOutput("t1_clear_cycles", clrCycles - c0, 1);
      checkOutput("t1_set_cycles", setCycles - s0, 1);
      checkOutput("t1_order", orderErrs - o0, 0);
      checkOutput("t1_input_changes", inputChanges - i0, 0);
      for (int i = 0; i < NUM_NEURONS; i++) checkPot("t1_pot", i, FP_10);

      $display("[TB] timesteps 2-5: accumulate to threshold");
      expPot[0] = FP_20; expPot[1] = FP_30; expPot[2] = FP_40; expPot[3] = FP_10;
      for (int t = 0; t < 4; t++) begin
         applyStimulus(1'b0, 0, -1, FP_0, FP_0, lat, dn, drops, bAfter, hits);
         expVec = (t == 3) ? '1 : '0;
         checkOutput("t2_latency", lat, LATENCY);
         checkOutput("t2_spike_vec", spike_vec, expVec);
         checkPot("t2_pot_first", 0, expPot[t]);
         checkPot("t2_pot_last", NUM_NEURONS - 1, expPot[t]);
      end

      $display("[TB] timestep: neuron 7 weight 50.0, others 0");
      for (int i = 0; i < NUM_NEURONS; i++) weights[i] = FP_0;
      weights[7] = FP_50;
      pot_init = 1'b1;
      @(posedge clk); #1;
      pot_init = 1'b0;
      applyStimulus(1'b0, 0, 7, FP_50, FP_0, lat, dn, drops, bAfter, hits);
      expVec = '0;
      expVec[7] = 1'b1;
      checkOutput("t3_latency", lat, LATENCY);
      checkOutput("t3_watch_hits", hits, ADDER_WAIT + 1);
      checkOutput("t3_spike_vec", spike_vec, expVec);
      checkPot("t3_pot7", 7, FP_10);
      checkPot("t3_pot6", 6, FP_0);
      checkPot("t3_pot8", 8, FP_0);
`ifdef SPIKE_COUNT_EN
      checkOutput("t3_spike_count", spike_count, 1);
`endif

      $display("[TB] timestep: extra start while busy");
      applyStimulus(1'b0, 20, 7, FP_50, FP_10, lat, dn, drops, bAfter, hits);
      checkOutput("t4_latency", lat, LATENCY);
      checkOutput("t4_done_count", dn, 1);
      checkOutput("t4_busy_drops", drops, 0);
      checkOutput("t4_spike_vec", spike_vec, expVec);
      checkPot("t4_pot7", 7, FP_20);

      $display("[TB] reset during evaluation of neuron 12");
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < LATENCY && !found; k++) begin
         if (wt_rd_en && wt_addr == IDX_W'(12)) found = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      checkOutput("t5_reached_n12", found, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput("t5_busy", busy, 1'b0);
      checkOutput("t5_done", done, 1'b0);
      checkOutput("t5_spike_vec", spike_vec, '0);
      checkOutput("t5_adder_in", {adder_weight, adder_potential}, 64'h0);
      checkPot("t5_pot7", 7, FP_0);
      checkPot("t5_pot11", 11, FP_0);
      dn = 0;
      cyc = 0;
      repeat (LATENCY) begin
         @(posedge clk); #1;
         if (done || busy) dn++;
         cyc++;
      end
      checkOutput("t5_quiet_after_reset", dn, 0);

      $display("[TB] timestep: distinct weights, adder input protocol");
      for (int i = 0; i < NUM_NEURONS; i++) weights[i] = intToFp(i + 1);
      c0 = clrCycles; s0 = setCycles; o0 = orderErrs; i0 = inputChanges;
      applyStimulus(1'b0, 0, NUM_NEURONS - 1, FP_30, FP_0, lat, dn, drops, bAfter, hits);
      checkOutput("t6_latency", lat, LATENCY);
      checkOutput("t6_watch_hits", hits, ADDER_WAIT + 1);
      checkOutput("t6_clear_cycles", clrCycles - c0, 1);
      checkOutput("t6_set_cycles", setCycles - s0, 1);
      checkOutput("t6_order", orderErrs - o0, 0);
      checkOutput("t6_input_changes", inputChanges - i0, 0);
      checkOutput("t6_spike_vec", spike_vec, '0);
      checkPot("t6_pot0", 0, FP_1);
      checkPot("t6_pot29", NUM_NEURONS - 1, FP_30);

      $display("[TB] timestep: pot_init and start in the same cycle");
      applyStimulus(1'b1, 0, 0, FP_1, FP_0, lat, dn, drops, bAfter, hits);
      checkOutput("t7_latency", lat, LATENCY);
      checkOutput("t7_watch_hits", hits, ADDER_WAIT + 1);
      checkPot("t7_pot0", 0, FP_1);
      checkPot("t7_pot29", NUM_NEURONS - 1, FP_30);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
